mc_divider: RTL and testbench

- Multicycle 32-bit integer divider. Responder side of the divide start/stall handshake used by the execute-stage ALU.
- Accepts single-cycle start pulses (signed or unsigned), iterates one quotient bit per cycle, then holds Quotient and Remainder stable for the ALU to commit into HILO.
- Stall reports "busy" for the entire operation.

---
 rtl/mc_divider.sv | 93 +++++++++
 tb/tb_mc_divider.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mc_divider.sv
// Multicycle restoring divider: one quotient bit per cycle, signed or unsigned,
// with a busy flag and results held until the next operation completes.
module mc_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  OP_div,
  input  logic                  OP_divu,
  input  logic [DATA_WIDTH-1:0] Dividend,
  input  logic [DATA_WIDTH-1:0] Divisor,
  output logic [DATA_WIDTH-1:0] Quotient,
  output logic [DATA_WIDTH-1:0] Remainder,
  output logic                  Stall
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] dvd_q;
  logic [DATA_WIDTH-1:0] dvs_q;
  logic                  neg_quo_q;
  logic                  neg_rem_q;

  logic [DATA_WIDTH:0]   shift_d;
  logic [DATA_WIDTH:0]   diff_d;
  logic                  last_d;

  // Two's-complement magnitude; the most negative value maps to 2^(W-1) as unsigned.
  function automatic logic [DATA_WIDTH-1:0] abs_val(input logic signed [DATA_WIDTH-1:0] v);
    return v[DATA_WIDTH-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] cond_neg(input logic [DATA_WIDTH-1:0] v,
                                                     input logic                  neg);
    return neg ? -v : v;
  endfunction

  // The W+1-bit difference borrows into its MSB exactly when the trial subtract fails.
  always_comb begin
    shift_d = {rem_q, dvd_q[DATA_WIDTH-1]};
    diff_d  = shift_d - {1'b0, dvs_q};
    last_d  = (cnt_q == CNT_W'(DATA_WIDTH - 1));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      Stall     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (OP_div || OP_divu) begin
            dvd_q     <= OP_div ? abs_val(Dividend) : Dividend;
            dvs_q     <= OP_div ? abs_val(Divisor)  : Divisor;
            neg_quo_q <= OP_div & (Dividend[DATA_WIDTH-1] ^ Divisor[DATA_WIDTH-1]);
            neg_rem_q <= OP_div & Dividend[DATA_WIDTH-1];
            rem_q     <= '0;
            cnt_q     <= '0;
            Stall     <= 1'b1;
            state_q   <= ITER;
          end
        end
        ITER: begin
          rem_q <= diff_d[DATA_WIDTH] ? shift_d[DATA_WIDTH-1:0] : diff_d[DATA_WIDTH-1:0];
          dvd_q <= {dvd_q[DATA_WIDTH-2:0], ~diff_d[DATA_WIDTH]};
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_d) state_q <= FIX;
        end
        FIX: begin
          Quotient  <= cond_neg(dvd_q, neg_quo_q);
          Remainder <= cond_neg(rem_q, neg_rem_q);
          Stall     <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_divider.sv
// Randomised and directed bench for mc_divider against an arithmetic reference model.
module tb_mc_divider;

  logic        clock;
  logic        reset;
  logic        OP_div;
  logic        OP_divu;
  logic [31:0] Dividend;
  logic [31:0] Divisor;
  logic [31:0] Quotient;
  logic [31:0] Remainder;
  logic        Stall;

  int total = 0;
  int bad   = 0;
  logic [31:0] prev_q = '0;
  logic [31:0] prev_r = '0;

  mc_divider #(.DATA_WIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .OP_div   (OP_div),
    .OP_divu  (OP_divu),
    .Dividend (Dividend),
    .Divisor  (Divisor),
    .Quotient (Quotient),
    .Remainder(Remainder),
    .Stall    (Stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: plain language-level division with the divide-by-zero and overflow rules.
  function automatic void model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = (sgn && sa < 0) ? 32'd1 : 32'hFFFF_FFFF;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (sa == 32'sh8000_0000 && sb == -1) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  // Issues a start at the current negedge and returns at the first negedge with Stall=0.
  task automatic do_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       input int intrude_at);
    int busy;
    logic [31:0] eq, er;
    model(sgn, a, b, eq, er);
    OP_div   = sgn;
    OP_divu  = !sgn;
    Dividend = a;
    Divisor  = b;
    @(negedge clock);
    OP_div   = 1'b0;
    OP_divu  = 1'b0;
    Dividend = $urandom;
    Divisor  = $urandom;
    busy = 0;
    while (Stall && busy < 100) begin
      busy++;
      if (busy == 16) begin
        check("hold_q", Quotient, prev_q);
        check("hold_r", Remainder, prev_r);
      end
      if (busy == intrude_at) begin
        OP_div   = 1'b1;
        Dividend = 32'd9;
        Divisor  = 32'd3;
      end
      @(negedge clock);
      OP_div  = 1'b0;
      OP_divu = 1'b0;
    end
    check("latency", busy, 33);
    check("quotient", Quotient, eq);
    check("remainder", Remainder, er);
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin
    reset    = 1'b0;
    OP_div   = 1'b0;
    OP_divu  = 1'b0;
    Dividend = '0;
    Divisor  = '0;
    #12;
    check("rst_stall", {31'd0, Stall}, 32'd0);
    check("rst_q", Quotient, 32'd0);
    check("rst_r", Remainder, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("idle_stall", {31'd0, Stall}, 32'd0);

    do_op(1'b0, 32'd100, 32'd7, -1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      check("held_q", Quotient, 32'd14);
      check("held_r", Remainder, 32'd2);
    end

    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1);
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, -1);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1, -1);
    do_op(1'b0, 32'd5, 32'd0, -1);
    do_op(1'b1, 32'hFFFF_FFF7, 32'd0, -1);
    do_op(1'b1, 32'd9, 32'd0, -1);

    // Start pulse while busy must be ignored.
    do_op(1'b0, 32'd100, 32'd7, 10);
    // Back-to-back: next start lands on the first Stall=0 cycle.
    do_op(1'b1, 32'hFFFF_FF00, 32'd13, -1);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(0, 15));
        1:       b = -32'($urandom_range(1, 15));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      do_op(1'($urandom_range(0, 1)), a, b, -1);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clock);
    end

    // Reset in the middle of an operation.
    OP_divu  = 1'b1;
    Dividend = 32'd1234567;
    Divisor  = 32'd3;
    @(negedge clock);
    OP_divu = 1'b0;
    repeat (14) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("midrst_stall", {31'd0, Stall}, 32'd0);
    check("midrst_q", Quotient, 32'd0);
    check("midrst_r", Remainder, 32'd0);
    @(negedge clock);
    reset  = 1'b1;
    prev_q = '0;
    prev_r = '0;
    @(negedge clock);
    do_op(1'b0, 32'd50, 32'd5, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
